// File: rtl/booth_mac.sv
// Pipelined radix-4 Booth multiply-accumulate unit with runtime operand
// signedness, valid/ready streaming and a sticky-overflow accumulator.
module booth_mac #(
  parameter int M_W            = 8,
  parameter int N_W            = 8,
  parameter int ROWS_PER_STAGE = 2,
  parameter int ACC_W          = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [M_W-1:0]     a,
  input  logic [N_W-1:0]     b,
  input  logic               a_signed,
  input  logic               b_signed,
  input  logic               acc_en,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [M_W+N_W-1:0] prod,
  output logic [ACC_W-1:0]   acc,
  output logic               acc_ovf
);

  localparam int NX  = (N_W % 2 == 1) ? N_W + 1 : N_W + 2;
  localparam int RHO = NX / 2;
  localparam int S   = (RHO + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
  localparam int P   = M_W + N_W;
  localparam int AW  = M_W + 1;
  localparam int BW  = NX + 1;

  // Stage 0 captures the raw beat; stages 1..S each retire up to
  // ROWS_PER_STAGE Booth rows. Sums are kept mod 2^P, which is exact
  // because every supported product fits in P bits.
  logic [S:0]   v, en, clr, sg;
  logic [AW-1:0] ar [0:S-1];
  logic [BW-1:0] br [0:S-1];
  logic [P-1:0]  sr [0:S];
  logic [P-1:0]  nsum [1:S];

  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  function automatic logic [P-1:0] row_pp(
    input logic [AW-1:0] x,
    input logic [BW-1:0] bx,
    input int            r
  );
    logic [2:0]   d;
    logic [P-1:0] xe;
    logic [P-1:0] t;
    d  = 3'(bx >> (2 * r));
    xe = P'(signed'(x));
    case (d)
      3'b001, 3'b010: t = xe;
      3'b011:         t = xe << 1;
      3'b100:         t = -(xe << 1);
      3'b101, 3'b110: t = -xe;
      default:        t = '0;
    endcase
    return t << (2 * r);
  endfunction

  // Add this stage's Booth rows onto the partial sum from the stage before.
  always_comb begin
    logic [P-1:0] t;
    int r;
    for (int s = 1; s <= S; s++) begin
      t = sr[s-1];
      for (int j = 0; j < ROWS_PER_STAGE; j++) begin
        r = (s - 1) * ROWS_PER_STAGE + j;
        if (r < RHO) t = t + row_pp(ar[s-1], br[s-1], r);
      end
      nsum[s] = t;
    end
  end

  logic [ACC_W-1:0] ext;
  logic [ACC_W:0]   sum;
  logic             ovf_add;

  // Extend the finished product and form the accumulate with its overflow.
  always_comb begin
    ext = sg[S] ? ACC_W'(signed'(sr[S])) : ACC_W'(sr[S]);
    sum = {1'b0, acc} + {1'b0, ext};
    if (sg[S])
      ovf_add = (acc[ACC_W-1] == ext[ACC_W-1]) &&
                (sum[ACC_W-1] != acc[ACC_W-1]);
    else
      ovf_add = sum[ACC_W];
  end

  // Pipeline advance and output/accumulator register; all hold on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v         <= '0;
      en        <= '0;
      clr       <= '0;
      sg        <= '0;
      for (int s = 0; s < S; s++) begin
        ar[s] <= '0;
        br[s] <= '0;
      end
      for (int s = 0; s <= S; s++) sr[s] <= '0;
      out_valid <= 1'b0;
      prod      <= '0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
    end else if (adv) begin
      v     <= {v[S-1:0], in_valid};
      en    <= {en[S-1:0], acc_en};
      clr   <= {clr[S-1:0], acc_clr};
      sg    <= {sg[S-1:0], a_signed | b_signed};
      ar[0] <= {a_signed & a[M_W-1], a};
      br[0] <= {NX'(signed'({b_signed & b[N_W-1], b})), 1'b0};
      for (int s = 1; s < S; s++) begin
        ar[s] <= ar[s-1];
        br[s] <= br[s-1];
      end
      sr[0] <= '0;
      for (int s = 1; s <= S; s++) sr[s] <= nsum[s];
      out_valid <= v[S];
      if (v[S]) begin
        prod <= sr[S];
        if (clr[S]) begin
          acc     <= ext;
          acc_ovf <= 1'b0;
        end else if (en[S]) begin
          acc     <= sum[ACC_W-1:0];
          acc_ovf <= acc_ovf | ovf_add;
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_mac.sv
// Scoreboard bench for booth_mac: default instance plus a 16-bit
// accumulator instance for the overflow case.
module tb_booth_mac;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p;
    logic [31:0] acc;
    logic        ovf;
    bit          lat;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  logic        iv0 = 0, as0 = 0, bs0 = 0, en0 = 0, clr0 = 0, or0 = 1;
  logic [7:0]  a0 = 0, b0 = 0;
  logic        ir0, ov0, ovf0;
  logic [15:0] p0;
  logic [31:0] acc0;

  logic        iv1 = 0, as1 = 0, bs1 = 0, en1 = 0, clr1 = 0, or1 = 1;
  logic [7:0]  a1 = 0, b1 = 0;
  logic        ir1, ov1, ovf1;
  logic [15:0] p1;
  logic [15:0] acc1;

  booth_mac dut0 (
    .clk(clk), .rst(rst),
    .in_valid(iv0), .in_ready(ir0),
    .a(a0), .b(b0), .a_signed(as0), .b_signed(bs0),
    .acc_en(en0), .acc_clr(clr0),
    .out_valid(ov0), .out_ready(or0),
    .prod(p0), .acc(acc0), .acc_ovf(ovf0)
  );

  booth_mac #(.ACC_W(16)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .a_signed(as1), .b_signed(bs1),
    .acc_en(en1), .acc_clr(clr1),
    .out_valid(ov1), .out_ready(or1),
    .prod(p1), .acc(acc1), .acc_ovf(ovf1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] ev);
    n_chk++;
    if (act !== ev) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, ev);
    end
  endtask

  task automatic cmp(input string tg, input exp_t e,
                     input logic [15:0] p, input logic [31:0] ac,
                     input logic ov, input logic ir, input logic ordy);
    chk({tg, "_prod"}, 32'(p), 32'(e.p));
    chk({tg, "_acc"}, ac, e.acc);
    chk({tg, "_ovf"}, 32'(ov), 32'(e.ovf));
    chk({tg, "_in_ready"}, 32'(ir), 32'(ordy));
    if (e.lat && ordy) chk({tg, "_latency"}, 32'(cyc - e.cyc), 32'd4);
  endtask

  // Monitor: outputs must match the queue head while valid; pop on handshake.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (ov0) begin
        if (q0.size() == 0) chk("dut0_unexpected_out", 32'd1, 32'd0);
        else begin
          cmp("dut0", q0[0], p0, acc0, ovf0, ir0, or0);
          if (or0) void'(q0.pop_front());
        end
      end
      if (ov1) begin
        if (q1.size() == 0) chk("dut1_unexpected_out", 32'd1, 32'd0);
        else begin
          cmp("dut1", q1[0], p1, {16'h0, acc1}, ovf1, ir1, or1);
          if (or1) void'(q1.pop_front());
        end
      end
    end
  end

  task automatic send(input int d, input logic [7:0] a, input logic [7:0] b,
                      input logic as, input logic bs,
                      input logic en, input logic clr,
                      input logic [15:0] ep, input logic [31:0] eacc,
                      input logic eovf, input bit lat);
    exp_t e;
    int   n;
    @(negedge clk);
    if (d == 0) begin
      iv0 = 1; a0 = a; b0 = b; as0 = as; bs0 = bs; en0 = en; clr0 = clr;
    end else begin
      iv1 = 1; a1 = a; b1 = b; as1 = as; bs1 = bs; en1 = en; clr1 = clr;
    end
    #1;
    n = 0;
    while ((d == 0) ? !ir0 : !ir1) begin
      n++;
      if (n > 50) begin
        chk("send_ready_timeout", 32'd1, 32'd0);
        break;
      end
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    e.p = ep; e.acc = eacc; e.ovf = eovf; e.lat = lat; e.cyc = cyc;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    iv0 = 0;
    iv1 = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("reset_out_valid", 32'(ov0), 32'd0);
    chk("reset_prod", 32'(p0), 32'd0);
    chk("reset_acc", acc0, 32'd0);
    chk("reset_ovf", 32'(ovf0), 32'd0);
    chk("reset_in_ready", 32'(ir0), 32'd1);

    send(0, 8'd255, 8'd255, 0, 0, 0, 1, 16'd65025, 32'd65025, 0, 1);
    idle();
    drain();

    send(0, 8'h80, 8'h80, 1, 1, 0, 1, 16'h4000, 32'h4000, 0, 1);
    send(0, 8'h80, 8'hFF, 1, 0, 0, 1, 16'h8080, 32'hFFFF8080, 0, 1);
    idle();
    drain();

    send(0, 8'd3, 8'd4, 0, 0, 0, 1, 16'd12, 32'd12, 0, 1);
    send(0, 8'd5, 8'd6, 0, 0, 1, 0, 16'd30, 32'd42, 0, 1);
    send(0, 8'd7, 8'd8, 0, 0, 1, 0, 16'd56, 32'd98, 0, 1);
    send(0, 8'd2, 8'd2, 0, 0, 0, 0, 16'd4, 32'd98, 0, 1);
    idle();
    drain();

    send(1, 8'd127, 8'd127, 1, 1, 0, 1, 16'd16129, 32'd16129, 0, 1);
    send(1, 8'd127, 8'd127, 1, 1, 1, 0, 16'd16129, 32'd32258, 0, 1);
    send(1, 8'd127, 8'd127, 1, 1, 1, 0, 16'd16129, 32'h0000BD03, 1, 1);
    send(1, 8'd1, 8'd1, 1, 1, 0, 1, 16'd1, 32'd1, 0, 1);
    idle();
    drain();

    fork
      begin
        send(0, 8'd10, 8'd20, 0, 0, 0, 1, 16'd200, 32'd200, 0, 0);
        send(0, 8'd15, 8'd15, 0, 0, 1, 0, 16'd225, 32'd425, 0, 0);
        send(0, 8'd100, 8'd3, 0, 0, 1, 0, 16'd300, 32'd725, 0, 0);
        send(0, 8'hFF, 8'hFF, 1, 1, 1, 0, 16'd1, 32'd726, 0, 0);
        send(0, 8'hFE, 8'h10, 1, 0, 1, 0, 16'hFFE0, 32'd694, 0, 0);
        send(0, 8'd0, 8'h77, 0, 0, 1, 0, 16'd0, 32'd694, 0, 0);
        idle();
      end
      begin
        repeat (6) @(negedge clk);
        or0 = 0;
        repeat (5) @(negedge clk);
        or0 = 1;
      end
    join
    drain();

    send(0, 8'd9, 8'd9, 0, 0, 0, 1, 16'd81, 32'd81, 0, 0);
    send(0, 8'd4, 8'd4, 0, 0, 1, 0, 16'd16, 32'd97, 0, 0);
    send(0, 8'd6, 8'd6, 0, 0, 1, 0, 16'd36, 32'd133, 0, 0);
    #1;
    rst = 1;
    iv0 = 0;
    #1;
    chk("midrst_out_valid", 32'(ov0), 32'd0);
    chk("midrst_prod", 32'(p0), 32'd0);
    chk("midrst_acc", acc0, 32'd0);
    chk("midrst_ovf", 32'(ovf0), 32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst = 0;
    repeat (8) @(negedge clk);
    send(0, 8'd2, 8'd3, 0, 0, 0, 1, 16'd6, 32'd6, 0, 1);
    idle();
    n = 0;
    while (!ov0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("post_reset_latency", 32'(n), 32'd4);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
